// File: rtl/morse_input_conditioner.sv
// Morse key front end: synchronises and debounces a raw key input, then
// classifies presses into dot/dash and released gaps into letter/word ends.
module morse_input_conditioner #(
    parameter int DEBOUNCE_CYC   = 500000,
    parameter int DOT_MAX_CYC    = 12500000,
    parameter int LETTER_GAP_CYC = 25000000,
    parameter int WORD_GAP_CYC   = 50000000,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       morse_in,
    output logic       key_down,
    output logic       sym_valid,
    output logic [1:0] sym_code,
    output logic       busy
);

    localparam int CW = $clog2(WORD_GAP_CYC + 1);

    localparam logic            IDLE_LEVEL = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0]   ONE        = CW'(1);
    localparam logic [CW-1:0]   DEB_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0]   DOT_MAX    = CW'(DOT_MAX_CYC);
    localparam logic [CW-1:0]   LETTER_GAP = CW'(LETTER_GAP_CYC);
    localparam logic [CW-1:0]   WORD_GAP   = CW'(WORD_GAP_CYC);

    localparam logic [1:0] CODE_DOT    = 2'b00;
    localparam logic [1:0] CODE_DASH   = 2'b01;
    localparam logic [1:0] CODE_LETTER = 2'b10;
    localparam logic [1:0] CODE_WORD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    logic          sync_1;
    logic          sync_2;
    logic          key_level;
    logic [CW-1:0] deb_cnt;
    logic          key_down_d;
    logic          key_rise;
    logic          key_fall;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] press_cnt;
    logic [CW-1:0] next_press_cnt;
    logic [CW-1:0] gap_cnt;
    logic [CW-1:0] next_gap_cnt;
    logic          next_sym_valid;
    logic [1:0]    next_sym_code;

    // Reset loads the released level so a held key is debounced afresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= IDLE_LEVEL;
            sync_2 <= IDLE_LEVEL;
        end else begin
            sync_1 <= morse_in;
            sync_2 <= sync_1;
        end
    end

    assign key_level = sync_2 ^ IDLE_LEVEL;

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt  <= '0;
            key_down <= 1'b0;
        end else if (key_level == key_down) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt  <= '0;
            key_down <= ~key_down;
        end else begin
            deb_cnt <= deb_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_down_d <= 1'b0;
        end else begin
            key_down_d <= key_down;
        end
    end

    assign key_rise = key_down & ~key_down_d;
    assign key_fall = ~key_down & key_down_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            press_cnt <= '0;
            gap_cnt   <= '0;
            sym_valid <= 1'b0;
            sym_code  <= CODE_DOT;
        end else begin
            state     <= next_state;
            press_cnt <= next_press_cnt;
            gap_cnt   <= next_gap_cnt;
            sym_valid <= next_sym_valid;
            sym_code  <= next_sym_code;
        end
    end

    // Key edges are tested before gap thresholds, so an edge that lands on
    // a threshold cycle suppresses that threshold's symbol.
    always_comb begin
        next_state     = state;
        next_press_cnt = press_cnt;
        next_gap_cnt   = gap_cnt;
        next_sym_valid = 1'b0;
        next_sym_code  = sym_code;

        case (state)
            IDLE: begin
                next_press_cnt = '0;
                next_gap_cnt   = '0;
                if (key_rise) begin
                    next_state     = PRESS;
                    next_press_cnt = ONE;
                end
            end

            PRESS: begin
                if (key_fall) begin
                    next_sym_valid = 1'b1;
                    next_sym_code  = (press_cnt < DOT_MAX) ? CODE_DOT : CODE_DASH;
                    next_state     = GAP;
                    next_gap_cnt   = ONE;
                end else if (press_cnt < DOT_MAX) begin
                    next_press_cnt = press_cnt + ONE;
                end
            end

            GAP: begin
                if (key_rise) begin
                    next_state     = PRESS;
                    next_press_cnt = ONE;
                end else if (gap_cnt == WORD_GAP) begin
                    next_sym_valid = 1'b1;
                    next_sym_code  = CODE_WORD;
                    next_state     = IDLE;
                    next_gap_cnt   = '0;
                end else begin
                    if (gap_cnt == LETTER_GAP) begin
                        next_sym_valid = 1'b1;
                        next_sym_code  = CODE_LETTER;
                    end
                    if (gap_cnt < WORD_GAP) begin
                        next_gap_cnt = gap_cnt + ONE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/morse_input_conditioner.md
MORSE_INPUT_CONDITIONER -- requirements
Module: morse_input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYC, default 500000, raw-input stable cycles required before the debounced level changes (10 ms at 50 MHz).
REQ-002 Parameter: DOT_MAX_CYC, default 12500000, press length below which a press is a dot; at or above, a dash.
REQ-003 Parameter: LETTER_GAP_CYC, default 25000000, released cycles that end a letter.
REQ-004 Parameter: WORD_GAP_CYC, default 50000000, released cycles that end a word; must exceed LETTER_GAP_CYC.
REQ-005 Parameter: ACTIVE_LOW, default 1, 1 means morse_in=0 is "key pressed".
REQ-006 Port: clk  input  1  single clock for all logic.
REQ-007 Port: reset  input  1  synchronous, active-high reset.
REQ-008 Port: morse_in  input  1  raw asynchronous key/button input.
REQ-009 Port: key_down  output  1  debounced, polarity-normalised key level (1 = pressed); drives the button LED.
REQ-010 Port: sym_valid  output  1  one-cycle strobe qualifying sym_code.
REQ-011 Port: sym_code  output  2  00 dot, 01 dash, 10 letter end, 11 word end.
REQ-012 Port: busy  output  1  high while a letter is in progress (state PRESS or GAP).

Function
REQ-013 morse_in shall pass through a 2-flop synchroniser before any other use; ACTIVE_LOW inversion shall be applied after it.
REQ-014 The debouncer shall count consecutive cycles where the synchronised level differs from key_down; the count shall clear on any match, and key_down shall toggle on the cycle the count reaches DEBOUNCE_CYC.
REQ-015 The FSM shall have states IDLE, PRESS and GAP, driven only by key_down edges and the timers.
REQ-016 IDLE -> PRESS on a key_down rising edge; the press counter shall load 1.
REQ-017 In PRESS, the press counter shall increment each cycle and saturate at DOT_MAX_CYC.
REQ-018 PRESS -> GAP on a key_down falling edge; on that cycle, sym_valid=1 and sym_code=00 if the press counter < DOT_MAX_CYC, else 01; the gap counter shall load 1.
REQ-019 In GAP, the gap counter shall increment each cycle and saturate at WORD_GAP_CYC.
REQ-020 In GAP, when the gap counter equals LETTER_GAP_CYC, the block shall emit sym_code=10 exactly once.
REQ-021 In GAP, when the gap counter equals WORD_GAP_CYC, the block shall emit sym_code=11 exactly once and go to IDLE.
REQ-022 GAP -> PRESS on a key_down rising edge before WORD_GAP_CYC; the press counter shall load 1.
REQ-023 If that press comes after the letter end was emitted, no further letter-end strobe shall occur for the gap already ended.
REQ-024 In IDLE no gap symbols shall be emitted, so a long idle period after reset produces no output.
REQ-025 At most one strobe shall occur per cycle.
REQ-026 An edge and a timer threshold can fall on the same cycle; the edge wins and the threshold symbol is dropped.
REQ-027 Counters shall be ceil(log2(WORD_GAP_CYC+1)) bits wide and shall never wrap.
REQ-028 Latency shall be: symbol strobe exactly 1 cycle after the key_down edge; key_down exactly 2+DEBOUNCE_CYC cycles after a stable raw change.
REQ-029 sym_code shall hold its last value between strobes; consumers shall sample it only when sym_valid=1.

Reset
REQ-030 While reset=1 on a clk edge: synchroniser flops shall be loaded with the inactive (released) level, and counters shall be 0.
REQ-031 While reset=1 on a clk edge: state=IDLE, key_down=0, sym_valid=0, sym_code=00, busy=0.
REQ-032 Reset asserted mid-press or mid-gap shall abort with no strobe, and shall take priority over all other events on the same cycle.
REQ-033 A key held through reset release shall be debounced afresh; it registers as a press only after DEBOUNCE_CYC stable cycles.

Verification
REQ-034 Use parameters DEBOUNCE_CYC=4, DOT_MAX_CYC=10, LETTER_GAP_CYC=20, WORD_GAP_CYC=40, ACTIVE_LOW=1; bench shall cover the scenarios below.
REQ-035 Scenario: press 6 cycles post-debounce, then release -> one strobe 00, busy=1.
REQ-036 Scenario: press 15 cycles -> strobe 01; keep released 40 cycles -> strobe 10 at gap 20, strobe 11 at gap 40, then busy=0.
REQ-037 Scenario: raw glitches of 1-3 cycles -> key_down stays 0 and no strobe.
REQ-038 Scenario: dot, re-press at gap 12 -> no 10 strobe, second symbol emitted normally.
REQ-039 Scenario: reset pulse during a 30-cycle press -> no strobe, all outputs 0, next clean dot yields 00.
REQ-040 Scenario: press held 1000 cycles -> counter saturates, single strobe 01 on release.
